// File: rtl/dilithium_io_sequencer.sv
// Job-level controller for the Dilithium wrapper: accepts a command, starts core and adapter,
// gates the input stream with header-length checking and reports done/err/cycle count.
module dilithium_io_sequencer #(
    parameter int W     = 64,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_sec_lvl,
    output logic             start,
    output logic [1:0]       mode,
    output logic [2:0]       sec_lvl,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [W-1:0]     data_i,
    input  logic             last_i,
    output logic             dilithium_valid_i,
    input  logic             dilithium_ready_i,
    output logic [W-1:0]     dilithium_data_i,
    input  logic             out_beat,
    input  logic             out_last,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_HDR, S_MSG, S_DRAIN} state_e;

    state_e             state_q;
    logic [9:0]         hdr_cnt_q;
    logic [CYC_W-1:0]   cnt_q;
    logic [CYC_W-1:0]   cnt_d;
    logic               fwd_q;
    logic               cmd_ready_q;
    logic               start_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         mode_q;
    logic [2:0]         sec_q;
    logic [CYC_W-1:0]   cycles_q;
    logic               beat_s;

    // Header length in 64-bit words; any sec_lvl other than 2 or 3 is treated as level 5.
    function automatic logic [9:0] hdr_words(input logic [1:0] m, input logic [2:0] s);
        logic [9:0] n;
        case (m)
            2'd0: n = 10'd4;
            2'd1: begin
                case (s)
                    3'd2:    n = 10'd467;
                    3'd3:    n = 10'd656;
                    default: n = 10'd899;
                endcase
            end
            2'd2: begin
                case (s)
                    3'd2:    n = 10'd316;
                    3'd3:    n = 10'd500;
                    default: n = 10'd608;
                endcase
            end
            default: n = 10'd1;
        endcase
        return n;
    endfunction

    // Stream gating uses only the registered phase flag, so valid never feeds ready.
    always_comb begin
        ready_i           = fwd_q & dilithium_ready_i;
        dilithium_valid_i = fwd_q & valid_i;
        dilithium_data_i  = data_i;
        beat_s            = fwd_q & valid_i & dilithium_ready_i;
        if (cnt_q == {CYC_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CYC_W-1){1'b0}}, 1'b1};
        end
    end

    // Job FSM with all control outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= 10'd0;
            cnt_q       <= {CYC_W{1'b0}};
            fwd_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= 2'd0;
            sec_q       <= 3'd0;
            cycles_q    <= {CYC_W{1'b0}};
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        mode_q <= cmd_mode;
                        sec_q  <= cmd_sec_lvl;
                        cnt_q  <= {CYC_W{1'b0}};
                        if (cmd_mode == 2'd3) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q       <= 1'b0;
                            start_q     <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state_q     <= S_START;
                        end
                    end
                end
                S_START: begin
                    hdr_cnt_q <= hdr_words(mode_q, sec_q);
                    fwd_q     <= 1'b1;
                    state_q   <= S_HDR;
                end
                S_HDR: begin
                    if (beat_s) begin
                        if (hdr_cnt_q == 10'd1) begin
                            // Keygen has no message; for verify/sign an early end leaves nothing to wait for.
                            if ((mode_q == 2'd0) != last_i) begin
                                err_q <= 1'b1;
                            end
                            if ((mode_q == 2'd0) || last_i) begin
                                fwd_q   <= 1'b0;
                                state_q <= S_DRAIN;
                            end else begin
                                state_q <= S_MSG;
                            end
                        end else if (last_i) begin
                            err_q   <= 1'b1;
                            fwd_q   <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q - 10'd1;
                        end
                    end
                end
                S_MSG: begin
                    if (beat_s && last_i) begin
                        fwd_q   <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_beat && out_last) begin
                        done_q      <= 1'b1;
                        cycles_q    <= cnt_d;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    fwd_q       <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign start     = start_q;
    assign mode      = mode_q;
    assign sec_lvl   = sec_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_dilithium_io_sequencer.sv
// Table-driven self-checking bench for dilithium_io_sequencer with a stream scoreboard.
module tb_dilithium_io_sequencer;

    localparam int W     = 64;
    localparam int CYC_W = 32;
    localparam int LIMIT = 4000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [2:0]       cmd_sec_lvl;
    logic             start;
    logic [1:0]       mode;
    logic [2:0]       sec_lvl;
    logic             valid_i;
    logic             ready_i;
    logic [W-1:0]     data_i;
    logic             last_i;
    logic             dilithium_valid_i;
    logic             dilithium_ready_i;
    logic [W-1:0]     dilithium_data_i;
    logic             out_beat;
    logic             out_last;
    logic             done;
    logic             err;
    logic [CYC_W-1:0] cycles;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [1:0] m;
        logic [2:0] s;
        int         n_in;
        int         n_out;
        bit         stall;
        bit         hold;
        int         rst_at;
        bit         exp_err;
        int         exp_fwd;
    } job_t;

    job_t rows[9];

    dilithium_io_sequencer #(.W(W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_sec_lvl(cmd_sec_lvl),
        .start(start), .mode(mode), .sec_lvl(sec_lvl),
        .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i), .last_i(last_i),
        .dilithium_valid_i(dilithium_valid_i), .dilithium_ready_i(dilithium_ready_i),
        .dilithium_data_i(dilithium_data_i),
        .out_beat(out_beat), .out_last(out_last),
        .done(done), .err(err), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int r, input int i);
        logic [31:0] lo;
        lo = 32'(i) * 32'h9E37_79B1;
        return {16'hC0DE, 16'(r), lo};
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_start"}, 64'(start), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_cycles"}, 64'(cycles), 64'd0);
        chk({tag, "_mode"}, 64'(mode), 64'd0);
        chk({tag, "_sec_lvl"}, 64'(sec_lvl), 64'd0);
        chk({tag, "_ready_i"}, 64'(ready_i), 64'd0);
        chk({tag, "_dil_valid"}, 64'(dilithium_valid_i), 64'd0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_job(input int r);
        job_t j;
        int idx, pushed, fwd, outs, kf, extra_start, hold_bad, early_done;
        bit in_drain, drain_chk, fin, completed, aborted;
        logic [63:0] exp_w;
        j = rows[r];
        idx = 0; pushed = 0; fwd = 0; outs = 0; kf = 0;
        extra_start = 0; hold_bad = 0; early_done = 0;
        in_drain = 0; drain_chk = 0; fin = 0; completed = 0; aborted = 0;
        sb_q.delete();
        wait_idle();
        out_beat = 1'b0; out_last = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        cmd_valid = 1'b1; cmd_mode = j.m; cmd_sec_lvl = j.s;
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (fin) begin
                cmd_valid = 1'b0; out_beat = 1'b0; out_last = 1'b0; valid_i = 1'b0; last_i = 1'b0;
                #1;
                chk("done_pulse", 64'(done), 64'd1);
                chk("err_at_done", 64'(err), 64'(j.exp_err));
                chk("cycles", 64'(cycles), 64'(kf + 1));
                chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
                @(negedge clk);
                #1;
                chk("done_one_cycle", 64'(done), 64'd0);
                completed = 1;
                break;
            end
            if (j.rst_at != 0 && fwd == j.rst_at) begin
                rst_n = 1'b0; cmd_valid = 1'b0; valid_i = 1'b1; dilithium_ready_i = 1'b1;
                out_beat = 1'b0; out_last = 1'b0;
                #1;
                reset_checks("midjob_rst");
                @(negedge clk);
                rst_n = 1'b1; valid_i = 1'b0;
                aborted = 1;
                break;
            end
            if (k == 0) begin
                if (j.hold) begin
                    cmd_mode = j.m ^ 2'd1; cmd_sec_lvl = j.s ^ 3'd1;
                end else begin
                    cmd_valid = 1'b0; cmd_mode = j.m ^ 2'd1; cmd_sec_lvl = ~j.s;
                end
            end
            valid_i = (idx < j.n_in) && (j.stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            data_i  = word_of(r, idx);
            last_i  = (idx == j.n_in - 1);
            dilithium_ready_i = in_drain ? 1'b1 : (j.stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (valid_i && idx == pushed) begin
                sb_q.push_back(word_of(r, idx));
                pushed++;
            end
            if (k == 1) begin
                out_beat = 1'b1; out_last = 1'b1;
            end else if (in_drain && outs < j.n_out) begin
                out_beat = j.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                out_last = out_beat && (outs == j.n_out - 1);
                if (out_beat) outs++;
                if (out_last) begin
                    fin = 1; kf = k;
                end
            end else begin
                out_beat = 1'b0; out_last = 1'b0;
            end
            #1;
            if (k == 0) begin
                chk("start_latency", 64'(start), 64'd1);
                chk("err_cleared", 64'(err), 64'd0);
            end else if (start) begin
                extra_start++;
            end
            if (done) early_done++;
            if (mode !== j.m || sec_lvl !== j.s) hold_bad++;
            if (in_drain && !drain_chk) begin
                drain_chk = 1;
                chk("drain_ready_i", 64'(ready_i), 64'd0);
                chk("drain_dil_valid", 64'(dilithium_valid_i), 64'd0);
            end
            if (dilithium_valid_i && dilithium_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("fwd_data", dilithium_data_i, exp_w);
                end
                fwd++;
            end
            if (valid_i && ready_i) idx++;
            if (fwd == j.exp_fwd) in_drain = 1;
        end
        if (j.rst_at != 0) begin
            chk("reset_reached", 64'(aborted), 64'd1);
        end else begin
            chk("job_complete", 64'(completed), 64'd1);
            chk("fwd_count", 64'(fwd), 64'(j.exp_fwd));
            chk("no_extra_start", 64'(extra_start), 64'd0);
            chk("mode_sec_held", 64'(hold_bad), 64'd0);
            chk("no_early_done", 64'(early_done), 64'd0);
        end
        sb_q.delete();
    endtask

    initial begin
        //          mode  sec   n_in n_out stall hold rst  err fwd
        rows[0] = '{2'd0, 3'd2,    4, 480, 1'b0, 1'b0,   0, 1'b0,   4};
        rows[1] = '{2'd2, 3'd5,  618,  20, 1'b1, 1'b0,   0, 1'b0, 618};
        rows[2] = '{2'd1, 3'd3,  100,  10, 1'b0, 1'b0,   0, 1'b1, 100};
        rows[3] = '{2'd0, 3'd3,    5,   6, 1'b0, 1'b0,   0, 1'b1,   4};
        rows[4] = '{2'd1, 3'd7,  902,   8, 1'b0, 1'b1,   0, 1'b0, 902};
        rows[5] = '{2'd2, 3'd2,  317,  12, 1'b1, 1'b0,   0, 1'b0, 317};
        rows[6] = '{2'd1, 3'd2,  467,   4, 1'b0, 1'b0,   0, 1'b1, 467};
        rows[7] = '{2'd2, 3'd3,  510,   4, 1'b0, 1'b0, 505, 1'b0, 510};
        rows[8] = '{2'd0, 3'd5,    4,   3, 1'b0, 1'b0,   0, 1'b0,   4};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_sec_lvl = 3'd0;
        valid_i = 1'b1; data_i = '0; last_i = 1'b0; dilithium_ready_i = 1'b1;
        out_beat = 1'b0; out_last = 1'b0;
        #3;
        reset_checks("por");
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            run_job(r);
        end

        // Illegal mode: flagged immediately, no start, sequencer stays idle.
        wait_idle();
        cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_sec_lvl = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_no_start", 64'(start), 64'd0);
        chk("illegal_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("illegal_no_start_later", 64'(start), 64'd0);
        chk("illegal_err_sticky", 64'(err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dilithium_io_sequencer.md
Name: dilithium_io_sequencer

Overview:
- Job-level controller for the high-performance Dilithium wrapper.
- Accepts a command (mode, sec_lvl) and issues the one-cycle start to both the core and the output adapter.
- Holds mode/sec_lvl stable as configuration for the whole job and gates the external input stream into the core with length checking.
- Waits for the adapter's final output beat, then reports done, error and a job cycle count.

Parameters:
- W, 64, data word width (input stream and core data).
- CYC_W, 32, width of job cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer idle, command accepted on cmd_valid&&cmd_ready.
- cmd_mode  in  2  0 keygen, 1 verify, 2 sign, 3 illegal.
- cmd_sec_lvl  in  3  2, 3; any other value means level 5.
- start  out  1  one-cycle start to core and adapter.
- mode  out  2  latched mode, stable from start until next accept.
- sec_lvl  out  3  latched sec_lvl, same stability.
- valid_i  in  1  external input stream valid.
- ready_i  out  1  external input stream ready.
- data_i  in  W  external input data.
- last_i  in  1  external input end-of-stream.
- dilithium_valid_i  out  1  valid_i gated by state.
- dilithium_ready_i  in  1  core input ready.
- dilithium_data_i  out  W  data_i passthrough (combinational).
- out_beat  in  1  adapter valid_o&&ready_o.
- out_last  in  1  adapter last.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky error; cleared on next command accept.
- cycles  out  CYC_W  cycles from start to done of last job.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in IDLE after reset. start, done, err, cycles, mode, sec_lvl = 0. ready_i and dilithium_valid_i = 0.
- States: IDLE, START, HDR, MSG, DRAIN.
- IDLE: cmd_ready=1. On accept, latch mode/sec_lvl, clear err and cycle counter, then go to START. If cmd_mode=3, go instead to IDLE with err=1 and no start.
- START: start=1 for exactly one cycle. Load header count from the table below, then go to HDR.
- Header words (64-bit):
  - keygen: 4 at every level.
  - verify: 467 (lvl 2), 656 (lvl 3), 899 (lvl 5).
  - sign: 316 (lvl 2), 500 (lvl 3), 608 (lvl 5).
- HDR/MSG handshake:
  - ready_i=dilithium_ready_i and dilithium_valid_i=valid_i, in HDR and MSG only.
  - A beat is valid_i&&dilithium_ready_i.
  - The header counter decrements per beat; no combinational loop from valid to ready.
- HDR, last beat of header (count==1):
  - keygen requires last_i=1, then go to DRAIN.
  - verify/sign require last_i=0, then go to MSG.
  - Any mismatch sets err.
- HDR, last_i on an earlier beat: err=1, go to DRAIN (stream no longer forwarded).
- MSG: forward beats until a beat with last_i=1, then go to DRAIN. A zero-length message is not allowed: the MSG phase takes at least one beat.
- DRAIN: ready_i=0. On out_beat&&out_last, pulse done next cycle, load cycles, go to IDLE.
- Cycle counter:
  - Counts every cycle from START (inclusive) through the cycle the final out_beat occurs.
  - Saturates at all-ones; no wrap.
- Outputs mode/sec_lvl are registered; they change only on command accept.
- cmd_valid in any non-IDLE state is ignored (cmd_ready=0); the command is not queued.
- out_beat outside DRAIN is ignored for completion.
- rst_n low at any point forces the reset values asynchronously. The in-flight job is discarded and the next start re-initialises the core/adapter.
- Latency: accept → start 1 cycle; final output beat → done 1 cycle.

Test Plan:
- Keygen lvl2: accept mode 0/sec 2 → start at cycle+1; 4 input beats, last on the 4th; adapter 480 beats with last → done one cycle after, err=0, cycles equals measured span.
- Sign lvl5 with 10 message words, random dilithium_ready_i/valid_i stalls → exactly 618 beats forwarded, data intact; done after out_last; mode=2, sec_lvl=5 held throughout.
- Verify lvl3 with last_i on beat 100 (<656) → err=1, state DRAIN, ready_i=0; done after out_last; err cleared on next accept.
- Keygen with last_i=0 on beat 4 → err=1; cmd_mode=3 → err=1, no start pulse, cmd_ready stays 1.
- cmd_valid held during an active job → no second start until done; sec_lvl=7 → verify header length 899.
- rst_n asserted mid-MSG → all outputs to reset values immediately; new command after release runs cleanly.
